hex_print_ctrl: RTL and testbench
=================================

// Module: hex_print_ctrl
// PURPOSE
//  Sequencer that prints a WIDTH-bit value as ASCII hex over the serial TX path.
//  Walks the value MSB-nibble first and drives each nibble into the shared
//  registered nibble-to-ASCII ROM (1-cycle read latency).
//  Forwards each returned character to the UART transmitter with a busy
//  handshake, then optionally appends CR LF. Sits between test/debug logic and serial_tx.
// PARAMETERS
//  WIDTH    16  value width in bits; multiple of 4, >=4; NIBBLES = WIDTH/4
//  NEWLINE  1   1: append 8'h0D, 8'h0A after the last digit; 0: digits only
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request to print value; accepted only when busy=0
//  value        in   WIDTH  word to print; sampled on the accepted start cycle
//  busy         out  1      high from the cycle after accept until done pulses
//  done         out  1      1-cycle pulse after the final character is issued
//  rom_addr     out  4      nibble index to ROM
//  rom_data     in   8      ROM ASCII output, valid 1 cycle after rom_addr
//  tx_data      out  8      character to transmitter
//  new_tx_data  out  1      1-cycle strobe, tx_data valid this cycle
//  tx_busy      in   1      transmitter busy; no strobe while high
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, done, new_tx_data=0;
//   rom_addr=4'h0; tx_data=8'h00; shift reg, nibble counter, sent_q=0.
//  States: IDLE, FETCH, SEND, SEND_CR, SEND_LF, FIN.
//  IDLE: start=1 -> latch value into shift reg; cnt=NIBBLES-1; ->FETCH.
//   start while busy=1 is ignored (not queued).
//  FETCH: rom_addr = shift reg top nibble (registered output); ->SEND.
//  SEND: rom_addr held stable. Strobe when tx_busy=0 && sent_q=0:
//   new_tx_data=1, tx_data=rom_data. Then: cnt!=0 -> shift left 4, cnt-1, ->FETCH;
//   cnt==0 -> NEWLINE ? SEND_CR : FIN. If tx_busy=1 or sent_q=1: stay, no strobe.
//  SEND_CR / SEND_LF: same strobe rule with 8'h0D / 8'h0A; CR->LF->FIN.
//  FIN: done=1 for one cycle, busy=0 next cycle; ->IDLE.
//  sent_q = registered new_tx_data. Guarantees >=1 idle cycle after each strobe
//   so the transmitter's busy has time to rise.
//  Latency (tx_busy=0): accept edge -> first strobe 2 cycles later.
//   One char per 2 cycles. Total strobes = NIBBLES + 2*NEWLINE.
//  tx_busy held high: controller stalls indefinitely in SEND*; no data lost.
//  value changes after accept have no effect.
//  rst_n asserted mid-print: immediate abort to IDLE. No partial strobe, no done.
//  Counter width = max(1, $clog2(NIBBLES)); no wrap (cnt==0 exits loop).
// STRUCTURE
//  Shared package hex_print_pkg: state encoding localparams, ASCII_CR=8'h0D,
//   ASCII_LF=8'h0A.
//  No sub-module: nibble_rom stays external and shared via rom_addr/rom_data;
//   the bench instantiates it.
// TESTING
//  1. WIDTH=16, value=16'hBEEF, start, tx_busy=0 -> strobes "B","E","E","F",0D,0A;
//     first strobe 2 cycles after accept; done once; busy low after.
//  2. NEWLINE=0, value=16'h0009 -> exactly "0","0","0","9"; done after 4th strobe.
//  3. tx_busy high 10 cycles around 2nd char of 16'h1234 -> "2" strobed once,
//     on first cycle tx_busy=0; sequence intact.
//  4. start pulsed again mid-print with value 16'hFFFF -> ignored; output still
//     first value; next start after done prints "FFFF".
//  5. rst_n low during 3rd char -> all outputs 0 immediately; no done;
//     fresh start prints full value.
//  6. WIDTH=4, value=4'hA -> "A",0D,0A; back-to-back start the cycle after done
//     is accepted.

Source files
------------

// File: rtl/hex_print_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hex_print_pkg
// Brief   : State encoding and ASCII constants shared by the hex printer.
// Revision: 1.0  initial release
// ============================================================================
package hex_print_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_SEND_CR = 3'd3,
        ST_SEND_LF = 3'd4,
        ST_FIN     = 3'd5
    } hex_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // A single-nibble value still needs a 1-bit counter.
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage : hex_print_pkg
`default_nettype wire

// File: rtl/hex_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hex_print_ctrl
// Brief   : Prints a WIDTH-bit value as ASCII hex (MSB nibble first) through
//           an external registered nibble ROM and a busy-handshaked UART TX.
// Revision: 1.0  initial release
// ============================================================================
module hex_print_ctrl
    import hex_print_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter bit NEWLINE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic [7:0]       tx_data,
    output logic             new_tx_data,
    input  logic             tx_busy
);

    localparam int              c_nibbles  = WIDTH / 4;
    localparam int              c_cnt_w    = cnt_width(c_nibbles);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(c_nibbles - 1);

    hex_state_t           r_state;
    hex_state_t           w_state_next;
    logic [WIDTH-1:0]     r_shreg;
    logic [WIDTH-1:0]     w_shifted;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_rom_addr;
    logic [7:0]           r_tx_data;
    logic                 r_sent;
    logic                 w_accept;
    logic                 w_strobe;
    logic                 w_advance;
    logic                 w_last;
    logic [7:0]           w_char;

    generate
        if (WIDTH > 4) begin : g_shift
            assign w_shifted = {r_shreg[WIDTH-5:0], 4'h0};
        end else begin : g_no_shift
            assign w_shifted = '0;
        end
    endgenerate

    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_sent is the registered strobe; blocking on it forces one quiet cycle
    // after every character so tx_busy can rise before the next decision.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_strobe     = 1'b0;
        w_advance    = 1'b0;
        w_char       = rom_data;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy && !r_sent) begin
                    w_strobe = 1'b1;
                    if (!w_last) begin
                        w_advance    = 1'b1;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = NEWLINE ? ST_SEND_CR : ST_FIN;
                    end
                end
            end
            ST_SEND_CR: begin
                w_char = ASCII_CR;
                if (!tx_busy && !r_sent) begin
                    w_strobe     = 1'b1;
                    w_state_next = ST_SEND_LF;
                end
            end
            ST_SEND_LF: begin
                w_char = ASCII_LF;
                if (!tx_busy && !r_sent) begin
                    w_strobe     = 1'b1;
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The ROM address is loaded together with each new nibble so the ROM's
    // one-cycle latency is hidden behind the FETCH cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_rom_addr <= 4'h0;
            r_tx_data  <= 8'h00;
            r_sent     <= 1'b0;
        end else begin
            r_sent <= w_strobe;
            if (w_strobe) begin
                r_tx_data <= w_char;
            end
            if (w_accept) begin
                r_shreg    <= value;
                r_cnt      <= c_cnt_init;
                r_rom_addr <= value[WIDTH-1 -: 4];
            end else if (r_state == ST_FETCH) begin
                r_rom_addr <= r_shreg[WIDTH-1 -: 4];
            end else if (w_advance) begin
                r_shreg    <= w_shifted;
                r_cnt      <= r_cnt - c_cnt_w'(1);
                r_rom_addr <= w_shifted[WIDTH-1 -: 4];
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_FIN);
    assign rom_addr    = r_rom_addr;
    assign tx_data     = r_tx_data;
    assign new_tx_data = r_sent;

endmodule : hex_print_ctrl
`default_nettype wire

// File: tb/tb_hex_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hex_print_ctrl
// Brief   : Self-checking bench for hex_print_ctrl in three configurations.
// Revision: 1.0  initial release
// ============================================================================
module tb_hex_print_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  nt;
    logic [2:0]  tx_force;
    logic [2:0]  tx_auto_busy;
    logic [2:0]  auto_en;
    logic [2:0]  tx_busy;
    logic [2:0]  busy_smp;
    logic [2:0]  nt_prev;
    logic [15:0] val   [3];
    logic [3:0]  raddr [3];
    logic [7:0]  rdata [3];
    logic [7:0]  txd   [3];
    int          auto_cnt [3];

    logic [7:0]  cap [3][16];
    int          ncap [3];
    int          ndone [3];
    int          viol [3];
    int          done_at [3];

    int          total = 0;
    int          bad   = 0;
    int          inst_w  [3] = '{16, 16, 4};
    int          inst_nl [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    assign tx_busy = tx_force | tx_auto_busy;

    hex_print_ctrl #(.WIDTH(16), .NEWLINE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .value(val[0]),
        .busy(busy[0]), .done(done[0]), .rom_addr(raddr[0]), .rom_data(rdata[0]),
        .tx_data(txd[0]), .new_tx_data(nt[0]), .tx_busy(tx_busy[0]));

    hex_print_ctrl #(.WIDTH(16), .NEWLINE(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .value(val[1]),
        .busy(busy[1]), .done(done[1]), .rom_addr(raddr[1]), .rom_data(rdata[1]),
        .tx_data(txd[1]), .new_tx_data(nt[1]), .tx_busy(tx_busy[1]));

    hex_print_ctrl #(.WIDTH(4), .NEWLINE(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .value(val[2][3:0]),
        .busy(busy[2]), .done(done[2]), .rom_addr(raddr[2]), .rom_data(rdata[2]),
        .tx_data(txd[2]), .new_tx_data(nt[2]), .tx_busy(tx_busy[2]));

    // Shared registered nibble ROM, one copy per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rdata[i] <= (raddr[i] < 4'd10) ? (8'h30 + {4'h0, raddr[i]})
                                           : (8'h37 + {4'h0, raddr[i]});
        end
    end

    // Transmitter model: busy for a random 1..5 cycles after each strobe.
    always @(posedge clk) begin
        busy_smp <= tx_busy;
        for (int i = 0; i < 3; i++) begin
            if (!auto_en[i]) begin
                tx_auto_busy[i] <= 1'b0;
                auto_cnt[i]     <= 0;
            end else if (nt[i]) begin
                tx_auto_busy[i] <= 1'b1;
                auto_cnt[i]     <= int'($urandom_range(0, 4));
            end else if (auto_cnt[i] != 0) begin
                auto_cnt[i] <= auto_cnt[i] - 1;
            end else begin
                tx_auto_busy[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                nt_prev[i] = 1'b0;
            end else begin
                if (nt[i]) begin
                    if (busy_smp[i] || nt_prev[i]) viol[i]++;
                    if (ncap[i] < 16) cap[i][ncap[i]] = txd[i];
                    ncap[i]++;
                end
                if (done[i]) begin
                    ndone[i]++;
                    done_at[i] = ncap[i];
                end
                nt_prev[i] = nt[i];
            end
        end
    end

    // Reference: character k of the printout of v on a w-bit printer.
    function automatic logic [7:0] exp_char(input int w, input logic [15:0] v, input int k);
        int nib = w / 4;
        int d;
        if (k < nib) begin
            d = int'(v >> (4 * (nib - 1 - k))) % 16;
            return (d < 10) ? 8'(48 + d) : 8'(55 + d);
        end
        return (k == nib) ? 8'h0D : 8'h0A;
    endfunction

    task automatic clear_capture(input int i);
        ncap[i]    = 0;
        ndone[i]   = 0;
        viol[i]    = 0;
        done_at[i] = -1;
    endtask

    task automatic start_print(input int i, input logic [15:0] v);
        clear_capture(i);
        @(posedge clk); #1;
        start[i] = 1'b1;
        val[i]   = v;
        @(posedge clk); #1;
        start[i] = 1'b0;
        val[i]   = 16'($urandom);
    endtask

    task automatic wait_done(input int i, input int budget, output int lat);
        int cyc = 0;
        lat = -1;
        while (ndone[i] == 0 && cyc < budget) begin
            @(negedge clk); #1;
            if (lat < 0 && ncap[i] > 0) lat = cyc;
            cyc++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({busy[i], done[i], nt[i]} !== 3'b000) begin
                bad++;
                $display("FAIL reset_flags[%0d]: got %b want 000", i, {busy[i], done[i], nt[i]});
            end
            total++;
            if (raddr[i] !== 4'h0) begin
                bad++;
                $display("FAIL reset_rom_addr[%0d]: got %h want 0", i, raddr[i]);
            end
            total++;
            if (txd[i] !== 8'h00) begin
                bad++;
                $display("FAIL reset_tx_data[%0d]: got %h want 00", i, txd[i]);
            end
        end
    endtask

    task automatic test_beef();
        int lat;
        start_print(0, 16'hBEEF);
        wait_done(0, 200, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL beef_latency: got %0d want 2", lat); end
        total++;
        if (ncap[0] !== 6) begin bad++; $display("FAIL beef_count: got %0d want 6", ncap[0]); end
        for (int k = 0; k < 6 && k < ncap[0]; k++) begin
            total++;
            if (cap[0][k] !== exp_char(16, 16'hBEEF, k)) begin
                bad++;
                $display("FAIL beef_char[%0d]: got %h want %h", k, cap[0][k], exp_char(16, 16'hBEEF, k));
            end
        end
        total++;
        if (ndone[0] !== 1) begin bad++; $display("FAIL beef_done: got %0d want 1", ndone[0]); end
        @(posedge clk); #1;
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL beef_busy_after: got %b want 0", busy[0]); end
        total++;
        if (viol[0] !== 0) begin bad++; $display("FAIL beef_handshake: got %0d want 0", viol[0]); end
    endtask

    task automatic test_no_newline();
        int lat;
        start_print(1, 16'h0009);
        wait_done(1, 200, lat);
        total++;
        if (ncap[1] !== 4) begin bad++; $display("FAIL nonl_count: got %0d want 4", ncap[1]); end
        for (int k = 0; k < 4 && k < ncap[1]; k++) begin
            total++;
            if (cap[1][k] !== exp_char(16, 16'h0009, k)) begin
                bad++;
                $display("FAIL nonl_char[%0d]: got %h want %h", k, cap[1][k], exp_char(16, 16'h0009, k));
            end
        end
        total++;
        if (ndone[1] !== 1 || done_at[1] !== 4) begin
            bad++;
            $display("FAIL nonl_done: got count %0d at %0d want 1 at 4", ndone[1], done_at[1]);
        end
    endtask

    task automatic test_stall();
        int lat;
        int cyc = 0;
        start_print(0, 16'h1234);
        while (ncap[0] == 0 && cyc < 50) begin @(negedge clk); cyc++; end
        tx_force[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_force[0] = 1'b0;
        @(negedge clk); #1;
        total++;
        if (ncap[0] !== 1) begin bad++; $display("FAIL stall_hold: got %0d strobes want 1", ncap[0]); end
        @(negedge clk); #1;
        total++;
        if (ncap[0] !== 2 || cap[0][1] !== 8'h32) begin
            bad++;
            $display("FAIL stall_release: got %0d strobes char %h want 2 strobes char 32", ncap[0], cap[0][1]);
        end
        wait_done(0, 200, lat);
        total++;
        if (ncap[0] !== 6) begin bad++; $display("FAIL stall_count: got %0d want 6", ncap[0]); end
        for (int k = 0; k < 6 && k < ncap[0]; k++) begin
            total++;
            if (cap[0][k] !== exp_char(16, 16'h1234, k)) begin
                bad++;
                $display("FAIL stall_char[%0d]: got %h want %h", k, cap[0][k], exp_char(16, 16'h1234, k));
            end
        end
        total++;
        if (viol[0] !== 0) begin bad++; $display("FAIL stall_handshake: got %0d want 0", viol[0]); end
    endtask

    task automatic test_ignore_start();
        int lat;
        start_print(0, 16'h5A3C);
        repeat (3) @(posedge clk);
        #1 start[0] = 1'b1; val[0] = 16'hFFFF;
        @(posedge clk); #1 start[0] = 1'b0;
        wait_done(0, 200, lat);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (cap[0][k] !== exp_char(16, 16'h5A3C, k)) begin
                bad++;
                $display("FAIL ignore_char[%0d]: got %h want %h", k, cap[0][k], exp_char(16, 16'h5A3C, k));
            end
        end
        total++;
        if (ndone[0] !== 1 || ncap[0] !== 6) begin
            bad++;
            $display("FAIL ignore_done: got %0d done %0d chars want 1 done 6 chars", ndone[0], ncap[0]);
        end
        start_print(0, 16'hFFFF);
        wait_done(0, 200, lat);
        total++;
        if (ncap[0] !== 6) begin bad++; $display("FAIL ffff_count: got %0d want 6", ncap[0]); end
        for (int k = 0; k < 6 && k < ncap[0]; k++) begin
            total++;
            if (cap[0][k] !== exp_char(16, 16'hFFFF, k)) begin
                bad++;
                $display("FAIL ffff_char[%0d]: got %h want %h", k, cap[0][k], exp_char(16, 16'hFFFF, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int cyc = 0;
        start_print(0, 16'hC0DE);
        while (ncap[0] < 2 && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy[0], done[0], nt[0], raddr[0], txd[0]} !== 15'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got busy %b done %b strobe %b addr %h data %h want all 0",
                     busy[0], done[0], nt[0], raddr[0], txd[0]);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        total++;
        if (ndone[0] !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", ndone[0]); end
        start_print(0, 16'hC0DE);
        wait_done(0, 200, lat);
        total++;
        if (ncap[0] !== 6) begin bad++; $display("FAIL midreset_count: got %0d want 6", ncap[0]); end
        for (int k = 0; k < 6 && k < ncap[0]; k++) begin
            total++;
            if (cap[0][k] !== exp_char(16, 16'hC0DE, k)) begin
                bad++;
                $display("FAIL midreset_char[%0d]: got %h want %h", k, cap[0][k], exp_char(16, 16'hC0DE, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_print(2, 16'h000A);
        wait_done(2, 100, lat);
        total++;
        if (ncap[2] !== 3) begin bad++; $display("FAIL w4_count: got %0d want 3", ncap[2]); end
        for (int k = 0; k < 3 && k < ncap[2]; k++) begin
            total++;
            if (cap[2][k] !== exp_char(4, 16'h000A, k)) begin
                bad++;
                $display("FAIL w4_char[%0d]: got %h want %h", k, cap[2][k], exp_char(4, 16'h000A, k));
            end
        end
        clear_capture(2);
        @(posedge clk); #1 start[2] = 1'b1; val[2] = 16'h0003;
        @(posedge clk); #1 start[2] = 1'b0; val[2] = 16'h000C;
        total++;
        if (busy[2] !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy %b want 1", busy[2]); end
        wait_done(2, 100, lat);
        total++;
        if (ncap[2] !== 3 || ndone[2] !== 1) begin
            bad++;
            $display("FAIL b2b_count: got %0d chars %0d done want 3 chars 1 done", ncap[2], ndone[2]);
        end
        for (int k = 0; k < 3 && k < ncap[2]; k++) begin
            total++;
            if (cap[2][k] !== exp_char(4, 16'h0003, k)) begin
                bad++;
                $display("FAIL b2b_char[%0d]: got %h want %h", k, cap[2][k], exp_char(4, 16'h0003, k));
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        int          i;
        int          n;
        logic [15:0] v;
        for (int it = 0; it < 12; it++) begin
            i = int'($urandom_range(0, 2));
            v = 16'($urandom);
            if (i == 2) v = v & 16'h000F;
            n = inst_w[i] / 4 + 2 * inst_nl[i];
            auto_en[i] = 1'b1;
            start_print(i, v);
            wait_done(i, 400, lat);
            total++;
            if (ncap[i] !== n || ndone[i] !== 1 || viol[i] !== 0) begin
                bad++;
                $display("FAIL rand_shape[%0d] inst %0d value %h: got %0d chars %0d done %0d viol want %0d chars 1 done 0 viol",
                         it, i, v, ncap[i], ndone[i], viol[i], n);
            end
            for (int k = 0; k < n && k < ncap[i]; k++) begin
                total++;
                if (cap[i][k] !== exp_char(inst_w[i], v, k)) begin
                    bad++;
                    $display("FAIL rand_char[%0d.%0d] inst %0d: got %h want %h",
                             it, k, i, cap[i][k], exp_char(inst_w[i], v, k));
                end
            end
            auto_en[i] = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 3'b000;
        tx_force = 3'b000;
        auto_en  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            val[i] = 16'h0000;
            clear_capture(i);
        end
        #12;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        test_beef();
        test_no_newline();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hex_print_ctrl
`default_nettype wire
